// File: rtl/n_bf_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : n_bf_pipe_if
//  Description : Beat-level bus of the pipelined radix-2 butterfly: input
//                handshake plus operands, output handshake plus results and
//                the sticky saturation flag with its clear.
//  Revision    : 1.0  initial release
// ============================================================================
interface n_bf_pipe_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic                 in_scale;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] c;
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] w_r;
    logic signed [DW-1:0] w_i;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out1_r;
    logic signed [DW-1:0] out1_i;
    logic signed [DW-1:0] out2_r;
    logic signed [DW-1:0] out2_i;
    logic                 ovf;
    logic                 clr_ovf;

    // Upstream/downstream side that feeds beats and consumes results
    modport master (
        output in_valid, in_mode, in_scale, a, b, c, d, w_r, w_i,
        output out_ready, clr_ovf,
        input  in_ready, out_valid, out1_r, out1_i, out2_r, out2_i, ovf
    );

    // Butterfly side
    modport slave (
        input  in_valid, in_mode, in_scale, a, b, c, d, w_r, w_i,
        input  out_ready, clr_ovf,
        output in_ready, out_valid, out1_r, out1_i, out2_r, out2_i, ovf
    );
endinterface
`default_nettype wire

// File: rtl/n_bf_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : n_bf_pipe
//  Description : 3-stage radix-2 complex butterfly with twiddle multiply,
//                per-beat DIF/DIT mode and /2 scaling, round-half-up,
//                output saturation with sticky flag, valid/ready stall.
//  Revision    : 1.0  initial release
// ============================================================================
module n_bf_pipe #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    n_bf_pipe_if.slave  bus
);
    // Internal width: products need 2*DW+1, sum of two products 2*DW+2,
    // one spare bit keeps the rounding offset addition overflow-free.
    localparam int c_IW = 2 * DW + 3;
    localparam logic signed [c_IW-1:0] c_ONE = {{(c_IW-1){1'b0}}, 1'b1};
    localparam logic signed [c_IW-1:0] c_MAX = {{(c_IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_IW-1:0] c_MIN = {{(c_IW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Round-half-up: floor((v + 2^(s-1)) / 2^s), identity for s = 0
    function automatic logic signed [c_IW-1:0] f_rnd(input logic signed [c_IW-1:0] i_v,
                                                       input int i_s);
        logic signed [c_IW-1:0] w_h;
        if (i_s == 0) return i_v;
        w_h = c_ONE <<< (i_s - 1);
        return (i_v + w_h) >>> i_s;
    endfunction

    // Clamp to the DW-bit signed range, flagging when a clamp happened
    function automatic logic signed [DW-1:0] f_sat(input logic signed [c_IW-1:0] i_v,
                                                   output logic o_c);
        o_c = 1'b0;
        if (i_v > c_MAX) begin
            o_c = 1'b1;
            return c_MAX[DW-1:0];
        end
        if (i_v < c_MIN) begin
            o_c = 1'b1;
            return c_MIN[DW-1:0];
        end
        return i_v[DW-1:0];
    endfunction

    // Single global enable: everything advances together or holds together
    logic w_en;
    logic r_v1, r_v2, r_v3;
    assign w_en          = bus.out_ready | ~r_v3;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_v3;

    // ---------------- Stage 1 ----------------
    // r_s1_* carries x0+x1 (DIF) or x0 (DIT); r_p1_* carries x0-x1 (DIF)
    // or x1 (DIT), i.e. whichever value gets multiplied by the twiddle.
    logic                 r_m1, r_sc1;
    logic signed [DW:0]   r_s1_r, r_s1_i, r_p1_r, r_p1_i;
    logic signed [DW-1:0] r_w1_r, r_w1_i;
    logic signed [DW:0]   w_ax, w_bx, w_cx, w_dx;

    assign w_ax = {bus.a[DW-1], bus.a};
    assign w_bx = {bus.b[DW-1], bus.b};
    assign w_cx = {bus.c[DW-1], bus.c};
    assign w_dx = {bus.d[DW-1], bus.d};

    // Stage 1 register: capture beat, form sum/diff or pass x1 through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_m1   <= 1'b0;
            r_sc1  <= 1'b0;
            r_s1_r <= '0;
            r_s1_i <= '0;
            r_p1_r <= '0;
            r_p1_i <= '0;
            r_w1_r <= '0;
            r_w1_i <= '0;
        end else if (w_en) begin
            r_v1   <= bus.in_valid;
            r_m1   <= bus.in_mode;
            r_sc1  <= bus.in_scale;
            r_w1_r <= bus.w_r;
            r_w1_i <= bus.w_i;
            if (!bus.in_mode) begin
                r_s1_r <= w_ax + w_cx;
                r_s1_i <= w_bx + w_dx;
                r_p1_r <= w_ax - w_cx;
                r_p1_i <= w_bx - w_dx;
            end else begin
                r_s1_r <= w_ax;
                r_s1_i <= w_bx;
                r_p1_r <= w_cx;
                r_p1_i <= w_dx;
            end
        end
    end

    // ---------------- Stage 2 ----------------
    logic                   r_m2, r_sc2;
    logic signed [DW:0]     r_s2_r, r_s2_i;
    logic signed [2*DW:0]   r_pp_rr, r_pp_ii, r_pp_ri, r_pp_ir;
    logic signed [2*DW:0]   w_pr, w_pi, w_wr, w_wi;

    assign w_pr = {{DW{r_p1_r[DW]}}, r_p1_r};
    assign w_pi = {{DW{r_p1_i[DW]}}, r_p1_i};
    assign w_wr = {{(DW+1){r_w1_r[DW-1]}}, r_w1_r};
    assign w_wi = {{(DW+1){r_w1_i[DW-1]}}, r_w1_i};

    // Stage 2 register: the four partial products of the complex multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_m2    <= 1'b0;
            r_sc2   <= 1'b0;
            r_s2_r  <= '0;
            r_s2_i  <= '0;
            r_pp_rr <= '0;
            r_pp_ii <= '0;
            r_pp_ri <= '0;
            r_pp_ir <= '0;
        end else if (w_en) begin
            r_v2    <= r_v1;
            r_m2    <= r_m1;
            r_sc2   <= r_sc1;
            r_s2_r  <= r_s1_r;
            r_s2_i  <= r_s1_i;
            r_pp_rr <= w_pr * w_wr;
            r_pp_ii <= w_pi * w_wi;
            r_pp_ri <= w_pr * w_wi;
            r_pp_ir <= w_pi * w_wr;
        end
    end

    // ---------------- Stage 3 ----------------
    logic signed [c_IW-1:0] w_re, w_im, w_sr, w_si, w_tr, w_ti;
    logic signed [c_IW-1:0] w_pre1_r, w_pre1_i, w_pre2_r, w_pre2_i;
    logic signed [DW-1:0]   w_o1_r, w_o1_i, w_o2_r, w_o2_i;
    logic [3:0]             w_c;
    logic                   w_clamp;
    int                     w_s;

    assign w_re = {{2{r_pp_rr[2*DW]}}, r_pp_rr} - {{2{r_pp_ii[2*DW]}}, r_pp_ii};
    assign w_im = {{2{r_pp_ri[2*DW]}}, r_pp_ri} + {{2{r_pp_ir[2*DW]}}, r_pp_ir};
    assign w_sr = {{(c_IW-DW-1){r_s2_r[DW]}}, r_s2_r};
    assign w_si = {{(c_IW-DW-1){r_s2_i[DW]}}, r_s2_i};

    // Final rounding per mode, then saturation of all four results
    always_comb begin
        w_s  = r_sc2 ? 1 : 0;
        w_tr = f_rnd(w_re, FRAC);
        w_ti = f_rnd(w_im, FRAC);
        if (!r_m2) begin
            // DIF: product rounded once, scale folded into the same shift
            w_pre1_r = f_rnd(w_sr, w_s);
            w_pre1_i = f_rnd(w_si, w_s);
            w_pre2_r = f_rnd(w_re, FRAC + w_s);
            w_pre2_i = f_rnd(w_im, FRAC + w_s);
        end else begin
            // DIT: t rounded first, sums rounded again by the scale shift
            w_pre1_r = f_rnd(w_sr + w_tr, w_s);
            w_pre1_i = f_rnd(w_si + w_ti, w_s);
            w_pre2_r = f_rnd(w_sr - w_tr, w_s);
            w_pre2_i = f_rnd(w_si - w_ti, w_s);
        end
        w_o1_r  = f_sat(w_pre1_r, w_c[0]);
        w_o1_i  = f_sat(w_pre1_i, w_c[1]);
        w_o2_r  = f_sat(w_pre2_r, w_c[2]);
        w_o2_i  = f_sat(w_pre2_i, w_c[3]);
        w_clamp = |w_c;
    end

    logic                 r_ovf;
    logic signed [DW-1:0] r_o1_r, r_o1_i, r_o2_r, r_o2_i;

    // Stage 3 register: outputs load only for real beats so bubbles keep
    // the last result; ovf set beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3   <= 1'b0;
            r_o1_r <= '0;
            r_o1_i <= '0;
            r_o2_r <= '0;
            r_o2_i <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_en) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_o1_r <= w_o1_r;
                    r_o1_i <= w_o1_i;
                    r_o2_r <= w_o2_r;
                    r_o2_i <= w_o2_i;
                end
            end
            if (w_en && r_v2 && w_clamp)
                r_ovf <= 1'b1;
            else if (bus.clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    assign bus.out1_r = r_o1_r;
    assign bus.out1_i = r_o1_i;
    assign bus.out2_r = r_o2_r;
    assign bus.out2_i = r_o2_i;
    assign bus.ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_n_bf_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_n_bf_pipe
//  Description : Scoreboard bench for n_bf_pipe: directed and random beats,
//                expected results from an arithmetic reference model,
//                random backpressure, mid-stream reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_n_bf_pipe;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam longint c_MAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint c_MIN = -(64'sd1 <<< (DW - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    n_bf_pipe_if #(.DW(DW)) bus();

    n_bf_pipe #(.DW(DW), .FRAC(FRAC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint o1r;
        longint o1i;
        longint o2r;
        longint o2i;
        bit     clamp;
    } ent_t;

    ent_t sb[$];
    ent_t last;
    ent_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    function automatic longint rnd(longint v, int s);
        if (s == 0) return v;
        return (v + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

    function automatic longint sat(longint v, inout bit c);
        if (v > c_MAX) begin c = 1; return c_MAX; end
        if (v < c_MIN) begin c = 1; return c_MIN; end
        return v;
    endfunction

    function automatic ent_t model(bit m, bit s, longint a, longint b, longint c,
                                   longint d, longint wr, longint wi);
        ent_t   e;
        longint p1r, p1i, p2r, p2i, dr, di, tr, ti;
        int     sc;
        sc = s ? 1 : 0;
        if (!m) begin
            dr  = a - c;
            di  = b - d;
            p1r = rnd(a + c, sc);
            p1i = rnd(b + d, sc);
            p2r = rnd(dr * wr - di * wi, FRAC + sc);
            p2i = rnd(dr * wi + di * wr, FRAC + sc);
        end else begin
            tr  = rnd(c * wr - d * wi, FRAC);
            ti  = rnd(c * wi + d * wr, FRAC);
            p1r = rnd(a + tr, sc);
            p1i = rnd(b + ti, sc);
            p2r = rnd(a - tr, sc);
            p2i = rnd(b - ti, sc);
        end
        e.clamp = 0;
        e.o1r = sat(p1r, e.clamp);
        e.o1i = sat(p1i, e.clamp);
        e.o2r = sat(p2r, e.clamp);
        e.o2i = sat(p2i, e.clamp);
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rv();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic drive(input bit m, input bit s, input int a, input int b, input int c,
                         input int d, input int wr, input int wi);
        bus.in_mode  = m;
        bus.in_scale = s;
        bus.a   = DW'(a);
        bus.b   = DW'(b);
        bus.c   = DW'(c);
        bus.d   = DW'(d);
        bus.w_r = DW'(wr);
        bus.w_i = DW'(wi);
    endtask

    // Offer one beat until accepted; optionally check 3-cycle latency
    task automatic send(input bit m, input bit s, input int a, input int b, input int c,
                        input int d, input int wr, input int wi, input bit lat);
        bit got;
        got = 0;
        drive(m, s, a, b, c, d, wr, wi);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                sb.push_back(model(m, s, a, b, c, d, wr, wi));
            end
        end
        if (!got) chk("send_accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (lat) begin
            @(negedge clk); chk("latency_cyc1_out_valid", bus.out_valid, 0);
            @(negedge clk); chk("latency_cyc2_out_valid", bus.out_valid, 0);
            @(negedge clk); chk("latency_cyc3_out_valid", bus.out_valid, 1);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) ok = 1;
        end
        chk("drain_done", ok, 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    // Compares the queue head every cycle a result is presented, so a held
    // (stalled) output is rechecked; pops only when the beat is taken.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got (%0d,%0d,%0d,%0d) expected no beat",
                         bus.out1_r, bus.out1_i, bus.out2_r, bus.out2_i);
            end else begin
                mon_e = sb[0];
                checks++;
                if (bus.out1_r != mon_e.o1r || bus.out1_i != mon_e.o1i ||
                    bus.out2_r != mon_e.o2r || bus.out2_i != mon_e.o2i) begin
                    errors++;
                    $display("FAIL out_data: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)",
                             bus.out1_r, bus.out1_i, bus.out2_r, bus.out2_i,
                             mon_e.o1r, mon_e.o1i, mon_e.o2r, mon_e.o2i);
                end
                if (mon_e.clamp) begin
                    checks++;
                    if (!bus.ovf) begin
                        errors++;
                        $display("FAIL ovf_on_clamp: got %0d expected 1", bus.ovf);
                    end
                end
                if (bus.out_ready) begin
                    last = mon_e;
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int  bpd[5][6];
    bit  bpm[5];
    int  idx;
    bit  rdone;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_out1_r", bus.out1_r, 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // DIF, unit twiddle, with latency check
        send(0, 0, 100, 50, 20, 10, 256, 0, 1);
        drain();
        chk("dif_out1_r", last.o1r, 120);
        chk("dif_out1_i", last.o1i, 60);
        chk("dif_out2_r", last.o2r, 80);
        chk("dif_out2_i", last.o2i, 40);

        // DIF, twiddle j
        send(0, 0, 100, 50, 20, 10, 0, 256, 0);
        drain();
        chk("dif_j_out2_r", last.o2r, -40);
        chk("dif_j_out2_i", last.o2i, 80);

        // Round-half-up, positive and negative halves
        send(0, 0, 3, 0, 0, 0, 128, 0, 0);
        drain();
        chk("rnd_pos_out2_r", last.o2r, 2);
        send(0, 0, -3, 0, 0, 0, 128, 0, 0);
        drain();
        chk("rnd_neg_out2_r", last.o2r, -1);

        // Saturation and sticky flag
        send(0, 0, 32767, 0, 1, 0, 256, 0, 0);
        drain();
        chk("sat_out1_r", last.o1r, 32767);
        chk("sat_ovf_set", bus.ovf, 1);
        @(posedge clk); #1 bus.clr_ovf = 1'b1;
        @(posedge clk); #1 bus.clr_ovf = 1'b0;
        chk("ovf_cleared", bus.ovf, 0);
        send(0, 1, 32767, 0, 1, 0, 256, 0, 0);
        drain();
        chk("scale_out1_r", last.o1r, 16384);
        chk("scale_out2_r", last.o2r, 16383);
        chk("scale_ovf_clear", bus.ovf, 0);

        // DIT
        send(1, 0, 10, 0, 4, 2, 0, 256, 0);
        drain();
        chk("dit_out1_r", last.o1r, 8);
        chk("dit_out1_i", last.o1i, 4);
        chk("dit_out2_r", last.o2r, 12);
        chk("dit_out2_i", last.o2i, -4);

        // Back-to-back alternating DIF/DIT
        for (int i = 0; i < 12; i++)
            send(i[0], 1'($urandom_range(1)), rv(), rv(), rv(), rv(), rv(), rv(), 0);
        drain();

        // Backpressure: 5 beats offered against a stalled sink
        for (int i = 0; i < 5; i++) begin
            bpm[i] = 1'($urandom_range(1));
            for (int j = 0; j < 6; j++) bpd[i][j] = rv();
        end
        bus.out_ready = 1'b0;
        idx = 0;
        drive(bpm[0], 0, bpd[0][0], bpd[0][1], bpd[0][2], bpd[0][3], bpd[0][4], bpd[0][5]);
        bus.in_valid = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.in_ready && idx < 5) begin
                sb.push_back(model(bpm[idx], 0, bpd[idx][0], bpd[idx][1], bpd[idx][2],
                                   bpd[idx][3], bpd[idx][4], bpd[idx][5]));
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 5)
                drive(bpm[idx], 0, bpd[idx][0], bpd[idx][1], bpd[idx][2],
                      bpd[idx][3], bpd[idx][4], bpd[idx][5]);
        end
        @(negedge clk);
        chk("bp_accepted", idx, 3);
        chk("bp_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 3; i < 5; i++)
            send(bpm[i], 0, bpd[i][0], bpd[i][1], bpd[i][2], bpd[i][3], bpd[i][4], bpd[i][5], 0);
        drain();

        // Random beats with random sink backpressure
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(1'($urandom_range(1)), 1'($urandom_range(1)),
                         rv(), rv(), rv(), rv(), rv(), rv(), 0);
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(2) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Mid-stream reset with two beats in flight
        send(0, 0, 32767, 0, 1, 0, 256, 0, 0);
        drain();
        chk("pre_rst_ovf", bus.ovf, 1);
        drive(0, 0, 100, 50, 20, 10, 256, 0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 drive(1, 0, 10, 0, 4, 2, 0, 256);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_ovf", bus.ovf, 0);
        chk("mid_rst_out1_r", bus.out1_r, 0);
        chk("mid_rst_out2_i", bus.out2_i, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1, 0, 10, 0, 4, 2, 0, 256, 1);
        drain();
        chk("post_rst_out2_i", last.o2i, -4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
